uart_instr_loader: RTL and testbench
====================================

Name: uart_instr_loader

Overview:
- Parametrised successor to the board-level UART instruction capture path.
- Accepts a byte stream from the UART receiver or its FIFO over a valid/ready handshake.
- Assembles bytes or nibbles LSB-first into DATA_W-bit words and writes them through a single write port into an external instruction RAM; the full memory array is not exposed.
- Detects a configurable end marker, flags overflow, and pulses trigger_upload so the CPU/uploader can start.

Parameters:
- DATA_W, 32, instruction word width; multiple of 8.
- DEPTH, 1024, instruction RAM depth in words.
- ADDR_W, $clog2(DEPTH), write address width.
- NIB_MODE, 1: each byte carries one nibble in bits [3:0], upper bits ignored; 0: each byte is a full byte.
- END_WORD, 32'hFFFF_FFFF, end-of-program marker; width DATA_W.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; clears the loader and begins a new load
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- wr_en  out  1  instruction RAM write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- word_count  out  ADDR_W+1  words written in the current load
- trigger_upload  out  1  one-cycle pulse when a load completes
- overflow  out  1  sticky; more than DEPTH words were received
- busy  out  1  high in ASSEMBLE or WRITE

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; unit counter, pointer and word_count all 0; assembly register 0.
  - wr_en=0, trigger_upload=0, overflow=0, busy=0.
  - rx_ready is combinational from state and start.
- Units per word: U = NIB_MODE ? DATA_W/4 : DATA_W/8; unit width UW = NIB_MODE ? 4 : 8.
- A transfer occurs when rx_valid && rx_ready on a rising clock edge.
- Unit k is written to bits [k*UW +: UW]. After each transfer, k increments and wraps to 0 after U-1.
- States:
  - IDLE: rx_ready=1. On the first transfer, store unit 0 and go to ASSEMBLE, or straight to WRITE if U==1.
  - ASSEMBLE: rx_ready=1. On the transfer of unit U-1, go to WRITE.
  - WRITE (exactly 1 cycle): rx_ready=0. Compare the assembled word with END_WORD.
    - Equal: no write; trigger_upload=1 for this cycle; go to DONE. The end marker is never written and not counted.
    - Not equal, pointer < DEPTH: wr_en=1, wr_addr=pointer, wr_data=assembled word. Pointer and word_count increment; clear the assembly register; go to ASSEMBLE.
    - Not equal, pointer == DEPTH: no write; overflow=1; trigger_upload=1; go to DONE.
  - DONE: rx_ready=0; incoming bytes are held off by the upstream FIFO. Stay until start.
- start in any state:
  - Next state IDLE; pointer, word_count, k, assembly register and overflow are cleared.
  - rx_ready=0 in the start cycle, so no byte is accepted.
  - A WRITE in progress in the same cycle is suppressed: wr_en=0.
- Latency: wr_en asserts exactly 1 cycle after the transfer of the final unit of a word. Sustained throughput is one word per U+1 cycles.
- wr_en, wr_addr and wr_data are registered outputs. wr_addr and wr_data hold their last values when wr_en=0.
- Only reset_n or start clears overflow.

Optional Feature:
- Macro: UART_INSTR_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running modular sum is kept over all accepted rx_data bytes of a load, including the end-marker bytes. In NIB_MODE the full byte is summed.
  - After the end marker the FSM enters CHK (rx_ready=1) and accepts one more byte.
  - trigger_upload then pulses with output checksum_ok = (byte == sum).
  - checksum_ok holds until start or reset; its reset value is 0.
  - On overflow, checksum_ok=0 and CHK is skipped.
- Disabled: no CHK state and no checksum_ok port; end marker goes directly to DONE.

Test Plan:
- NIB_MODE=1, bytes 0x01..0x08, then eight 0x0F → wr_en once with wr_addr=0 and wr_data=0x87654321; trigger_upload pulses 1 cycle after the last 0x0F; word_count=1; rx_ready=0 afterwards.
- NIB_MODE=0, bytes EF BE AD DE 78 56 34 12, then FF×4 → writes 0xDEADBEEF@0 and 0x12345678@1; word_count=2; END_WORD not written.
- DEPTH=4, 5 non-end words → 4 writes (addresses 0..3); 5th word dropped; overflow=1; trigger_upload pulses; start clears overflow and word_count to 0.
- start asserted while rx_valid=1 during ASSEMBLE with 3 nibbles held → byte not accepted; the next 8 nibbles form a fresh word at wr_addr=0.
- reset_n low mid-word for 1 cycle (asynchronous) → all outputs 0 immediately; subsequent load starts at address 0.
- Checksum build: 1 word + end marker + correct sum byte → checksum_ok=1; wrong sum byte (sum+1) → checksum_ok=0, trigger_upload still pulses.

Source files
------------

// File: rtl/uart_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_instr_loader
// Brief    : Packs a UART byte/nibble stream into instruction words for an
//            external instruction RAM; optional checksum via the macro
//            UART_INSTR_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_instr_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter bit                NIB_MODE = 1'b1,
  parameter logic [DATA_W-1:0] END_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              trigger_upload,
  output logic              overflow,
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
  output logic              checksum_ok,
`endif
  output logic              busy
);

  localparam int              c_unit_w = NIB_MODE ? 4 : 8;
  localparam int              c_units  = DATA_W / c_unit_w;
  localparam int              c_kw     = (c_units > 1) ? $clog2(c_units) : 1;
  localparam logic [c_kw-1:0] c_last_k = c_kw'(c_units - 1);
  localparam logic [c_kw-1:0] c_k_one  = c_kw'(1);
  localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_p_one  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSEMBLE = 3'd1,
    S_WRITE    = 3'd2,
    S_DONE     = 3'd3,
    S_CHK      = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_kw-1:0]     r_k;
  logic [ADDR_W:0]     r_ptr;
  logic [DATA_W-1:0]   r_asm;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_trig;
  logic                r_ovf;
  logic [7:0]          r_sum;
  logic                r_chk_ok;
  logic                w_xfer;
  logic [c_unit_w-1:0] w_unit;
  logic                w_unused_bits;

  assign w_unit        = rx_data[c_unit_w-1:0];
  assign w_unused_bits = ^{rx_data, r_sum, r_chk_ok};
  assign w_xfer        = rx_valid && rx_ready;

  // Acceptance is blocked combinationally in the start cycle so no byte leaks into the new load
  always_comb begin
    rx_ready = 1'b0;
    if (!start) begin
      case (r_state)
        S_IDLE, S_ASSEMBLE: rx_ready = 1'b1;
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
        S_CHK:              rx_ready = 1'b1;
`endif
        default:            rx_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_ptr     <= '0;
      r_asm     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_trig    <= 1'b0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_chk_ok  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_trig  <= 1'b0;
      if (start) begin
        r_state  <= S_IDLE;
        r_k      <= '0;
        r_ptr    <= '0;
        r_asm    <= '0;
        r_ovf    <= 1'b0;
        r_sum    <= '0;
        r_chk_ok <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_ASSEMBLE: begin
            if (w_xfer) begin
              r_asm[int'(r_k) * c_unit_w +: c_unit_w] <= w_unit;
              r_sum <= r_sum + rx_data;
              if (r_k == c_last_k) begin
                r_k     <= '0;
                r_state <= S_WRITE;
              end else begin
                r_k     <= r_k + c_k_one;
                r_state <= S_ASSEMBLE;
              end
            end
          end
          S_WRITE: begin
            // End marker wins over the capacity check and is never stored
            if (r_asm == END_WORD) begin
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_trig  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else if (r_ptr < c_depth) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr[ADDR_W-1:0];
              r_wr_data <= r_asm;
              r_ptr     <= r_ptr + c_p_one;
              r_asm     <= '0;
              r_state   <= S_ASSEMBLE;
            end else begin
              r_ovf    <= 1'b1;
              r_trig   <= 1'b1;
              r_chk_ok <= 1'b0;
              r_state  <= S_DONE;
            end
          end
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (w_xfer) begin
              r_chk_ok <= (rx_data == r_sum);
              r_trig   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign wr_en          = r_wr_en;
  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign word_count     = r_ptr;
  assign trigger_upload = r_trig;
  assign overflow       = r_ovf;
  assign busy           = (r_state == S_ASSEMBLE) || (r_state == S_WRITE);
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
  assign checksum_ok    = r_chk_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_instr_loader
// Brief    : Self-checking bench; nibble-mode (DEPTH 1024) and byte-mode
//            (DEPTH 4) instances checked against a word-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_instr_loader;

  localparam logic [31:0] c_end = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n   = 1'b0;
  int         cur       = 0;
  logic       drv_start = 1'b0;
  logic       drv_rxv   = 1'b0;
  logic [7:0] drv_rxd   = 8'h00;
  int         cyc       = 0;
  int         n_cmp     = 0;
  int         n_err     = 0;
  bit         gaps      = 0;
  bit         rand_hi   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        st0, st1, v0, v1;
  logic        rdy0, we0, tr0, ov0, bz0, ck0;
  logic        rdy1, we1, tr1, ov1, bz1, ck1;
  logic [9:0]  wa0;
  logic [10:0] wc0;
  logic [1:0]  wa1;
  logic [2:0]  wc1;
  logic [31:0] wd0, wd1;

  assign st0 = drv_start && (cur == 0);
  assign st1 = drv_start && (cur == 1);
  assign v0  = drv_rxv && (cur == 0);
  assign v1  = drv_rxv && (cur == 1);

  uart_instr_loader #(.DATA_W(32), .DEPTH(1024), .NIB_MODE(1'b1)) u_nib (
    .clk(clk), .reset_n(reset_n), .start(st0), .rx_data(drv_rxd), .rx_valid(v0),
    .rx_ready(rdy0), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .word_count(wc0),
    .trigger_upload(tr0), .overflow(ov0),
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
    .checksum_ok(ck0),
`endif
    .busy(bz0)
  );

  uart_instr_loader #(.DATA_W(32), .DEPTH(4), .NIB_MODE(1'b0)) u_byte (
    .clk(clk), .reset_n(reset_n), .start(st1), .rx_data(drv_rxd), .rx_valid(v1),
    .rx_ready(rdy1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .word_count(wc1),
    .trigger_upload(tr1), .overflow(ov1),
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
    .checksum_ok(ck1),
`endif
    .busy(bz1)
  );

`ifndef UART_INSTR_LOADER_CHECKSUM_EN
  assign ck0 = 1'b0;
  assign ck1 = 1'b0;
`endif

  logic        m_ready, m_we, m_tr, m_ov, m_bz, m_ck;
  logic [10:0] m_wa, m_wc;
  logic [31:0] m_wd;
  assign m_ready = cur == 1 ? rdy1 : rdy0;
  assign m_we    = cur == 1 ? we1 : we0;
  assign m_tr    = cur == 1 ? tr1 : tr0;
  assign m_ov    = cur == 1 ? ov1 : ov0;
  assign m_bz    = cur == 1 ? bz1 : bz0;
  assign m_ck    = cur == 1 ? ck1 : ck0;
  assign m_wa    = cur == 1 ? 11'(wa1) : 11'(wa0);
  assign m_wc    = cur == 1 ? 11'(wc1) : wc0;
  assign m_wd    = cur == 1 ? wd1 : wd0;

  typedef struct packed {
    int          c;
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  int          trig_q[$];
  bit          mon_en = 0;
  logic [31:0] ld_words[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_we) wr_q.push_back('{c: cyc, a: m_wa, d: m_wd});
      if (m_tr) trig_q.push_back(cyc);
    end
  end

  task automatic pulse_start();
    drv_start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_ready !== 1'b0) begin
      n_err++;
      $display("FAIL start_blocks_ready: got %b exp 0", m_ready);
    end
    @(posedge clk); #1;
    drv_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int xc);
    bit acc = 0;
    int guard = 0;
    int g = gaps ? int'($urandom_range(0, 2)) : 0;
    drv_rxv = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    drv_rxd = b;
    drv_rxv = 1'b1;
    while (!acc && guard < 40) begin
      @(negedge clk);
      acc = m_ready;
      @(posedge clk); #1;
      guard++;
    end
    drv_rxv = 1'b0;
    xc = cyc;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, guard);
    end
  endtask

  // Expected behaviour derived word by word from the loader rules
  task automatic run_load(input string name, input bit do_start, input bit bad_sum);
    int          depth = (cur == 1) ? 4 : 1024;
    int          units = (cur == 1) ? 4 : 8;
    int          nw = 0, nsend = 0, xc = 0, exp_trig = 0;
    bit          ended = 0, ovf = 0;
    logic [7:0]  sum = 8'h00, b;
    logic [31:0] w;
    logic        exp_ck = 1'b0;
    int          last_c[$];
    if (do_start) pulse_start();
    wr_q.delete();
    trig_q.delete();
    mon_en = 1;
    for (int i = 0; i < ld_words.size(); i++) begin
      nsend++;
      if (ld_words[i] == c_end) begin ended = 1; break; end
      if (nw < depth) nw++;
      else begin ovf = 1; break; end
    end
    for (int i = 0; i < nsend; i++) begin
      w = ld_words[i];
      for (int u = 0; u < units; u++) begin
        if (cur == 0) b = {(rand_hi ? 4'($urandom_range(0, 15)) : 4'h0), w[4*u +: 4]};
        else          b = w[8*u +: 8];
        sum = sum + b;
        send_byte(b, xc);
      end
      last_c.push_back(xc);
    end
    exp_trig = last_c[nsend-1] + 1;
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
    if (ended) begin
      send_byte(bad_sum ? sum + 8'h01 : sum, xc);
      exp_ck   = !bad_sum;
      exp_trig = xc;
    end
`endif
    repeat (4) begin @(posedge clk); #1; end
    mon_en = 0;
    n_cmp++;
    if (wr_q.size() != nw) begin
      n_err++;
      $display("FAIL %s write_count: got %0d exp %0d", name, wr_q.size(), nw);
    end
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i].a !== 11'(i) || wr_q[i].d !== ld_words[i] || wr_q[i].c != last_c[i] + 1) begin
        n_err++;
        $display("FAIL %s write%0d: got addr %0d data %h cyc %0d exp addr %0d data %h cyc %0d",
                 name, i, wr_q[i].a, wr_q[i].d, wr_q[i].c, i, ld_words[i], last_c[i] + 1);
      end
    end
    n_cmp++;
    if (trig_q.size() != 1 || trig_q[0] != exp_trig) begin
      n_err++;
      $display("FAIL %s trigger: got %0d pulses first cyc %0d exp 1 pulse at cyc %0d",
               name, trig_q.size(), (trig_q.size() > 0) ? trig_q[0] : -1, exp_trig);
    end
    n_cmp++;
    if (m_wc !== 11'(nw) || m_ov !== ovf || m_ready !== 1'b0 || m_bz !== 1'b0) begin
      n_err++;
      $display("FAIL %s final_status: got wc %0d ovf %b rdy %b busy %b exp wc %0d ovf %b rdy 0 busy 0",
               name, m_wc, m_ov, m_ready, m_bz, nw, ovf);
    end
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
    n_cmp++;
    if (m_ck !== exp_ck) begin
      n_err++;
      $display("FAIL %s checksum_ok: got %b exp %b", name, m_ck, exp_ck);
    end
`endif
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      cur = d;
      #1;
      n_cmp++;
      if (m_we !== 0 || m_tr !== 0 || m_ov !== 0 || m_bz !== 0 || m_wc !== 0 ||
          m_wa !== 0 || m_wd !== 0 || m_ready !== 1'b1 || m_ck !== 0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got we %b tr %b ov %b bz %b wc %0d wa %0d wd %h rdy %b exp zeros rdy 1",
                 d, m_we, m_tr, m_ov, m_bz, m_wc, m_wa, m_wd, m_ready);
      end
    end
  endtask

  task automatic test_nib_directed();
    cur = 0; gaps = 0; rand_hi = 0;
    ld_words = '{32'h8765_4321, c_end};
    run_load("nib_directed", 1, 0);
  endtask

  task automatic test_byte_directed();
    cur = 1; gaps = 0;
    ld_words = '{32'hDEAD_BEEF, 32'h1234_5678, c_end};
    run_load("byte_directed", 1, 0);
  endtask

  task automatic test_overflow();
    cur = 1; gaps = 1;
    ld_words.delete();
    for (int i = 0; i < 5; i++) ld_words.push_back($urandom & 32'h7FFF_FFFF);
    run_load("overflow", 1, 0);
    pulse_start();
    n_cmp++;
    if (m_ov !== 1'b0 || m_wc !== 0) begin
      n_err++;
      $display("FAIL overflow_clear: got ovf %b wc %0d exp ovf 0 wc 0", m_ov, m_wc);
    end
  endtask

  task automatic test_start_abort();
    int xc;
    cur = 0; gaps = 0; rand_hi = 1;
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), xc);
    drv_rxd = 8'h0A;
    drv_rxv = 1'b1;
    pulse_start();
    drv_rxv = 1'b0;
    ld_words = '{$urandom & 32'h7FFF_FFFF, c_end};
    run_load("start_abort", 0, 0);
  endtask

  task automatic test_async_reset();
    int xc;
    cur = 0; gaps = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), xc);
    n_cmp++;
    if (m_bz !== 1'b1) begin
      n_err++;
      $display("FAIL busy_assemble: got %b exp 1", m_bz);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_bz !== 0 || m_wc !== 0 || m_wd !== 0 || m_wa !== 0 || m_ov !== 0 || m_we !== 0 || m_tr !== 0) begin
      n_err++;
      $display("FAIL async_reset: got bz %b wc %0d wd %h wa %0d ov %b we %b tr %b exp all 0",
               m_bz, m_wc, m_wd, m_wa, m_ov, m_we, m_tr);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    ld_words = '{$urandom & 32'h7FFF_FFFF, $urandom & 32'h7FFF_FFFF, c_end};
    run_load("after_reset", 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int n;
    for (int it = 0; it < 8; it++) begin
      cur = it % 2; gaps = 1; rand_hi = 1;
      n = int'($urandom_range(1, (cur == 1) ? 6 : 4));
      ld_words.delete();
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == c_end) w = 32'h0;
        ld_words.push_back(w);
      end
      ld_words.push_back(c_end);
      run_load($sformatf("random%0d", it), 1, 0);
    end
  endtask

`ifdef UART_INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    cur = 0; gaps = 1; rand_hi = 1;
    ld_words = '{$urandom & 32'h7FFF_FFFF, c_end};
    run_load("checksum_good", 1, 0);
    ld_words = '{$urandom & 32'h7FFF_FFFF, c_end};
    run_load("checksum_bad", 1, 1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_nib_directed();
    test_byte_directed();
    test_overflow();
    test_start_abort();
    test_async_reset();
    test_random();
`ifdef UART_INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
